// File: rtl/ncc_data_feeder.sv
// Transmit-side front end for the NCC matcher: buffers one descriptor, replays it as a
// 64-cycle burst, then assembles and presents NUM_WINDOWS search windows one at a time.
module ncc_data_feeder #(
    parameter int NUM_WINDOWS = 4,
    parameter int PIX_W       = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4*PIX_W-1:0]   in_data,
    output logic                 in_ready,
    output logic [4*PIX_W-1:0]   desc_out,
    output logic                 desc_data_ready,
    output logic [256*PIX_W-1:0] win_out,
    output logic                 window_data_ready,
    input  logic                 done_with_window_data,
    input  logic                 done_with_desc_data,
    output logic [8:0]           win_index,
    output logic                 frame_done
);

    localparam int         BEAT_W   = 4 * PIX_W;
    localparam logic [8:0] LAST_WIN = 9'(NUM_WINDOWS - 1);

    typedef enum logic [2:0] {
        LOAD_DESC,
        SEND_DESC,
        LOAD_WIN,
        FIRE_WIN,
        WAIT_WIN,
        WAIT_DESC
    } state_t;

    state_t            state;
    logic [5:0]        beat_cnt;
    logic [5:0]        send_cnt;
    logic [BEAT_W-1:0] desc_buf [64];
    logic [BEAT_W-1:0] beat_swz;
    logic              accept;

    assign accept = in_valid && in_ready;

    // in_data carries the lowest-index pixel in its top slice, win_out in its bottom one.
    always_comb begin
        beat_swz = '0;
        for (int j = 0; j < 4; j++) begin
            beat_swz[j*PIX_W +: PIX_W] = in_data[(3-j)*PIX_W +: PIX_W];
        end
    end

    // Every entry is rewritten before each replay, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD_DESC && accept) begin
            desc_buf[beat_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= LOAD_DESC;
            beat_cnt          <= '0;
            send_cnt          <= '0;
            in_ready          <= 1'b0;
            desc_out          <= '0;
            desc_data_ready   <= 1'b0;
            win_out           <= '0;
            window_data_ready <= 1'b0;
            win_index         <= '0;
            frame_done        <= 1'b0;
        end else begin
            window_data_ready <= 1'b0;
            frame_done        <= 1'b0;
            case (state)
                LOAD_DESC: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == 6'd63) begin
                            state           <= SEND_DESC;
                            in_ready        <= 1'b0;
                            desc_data_ready <= 1'b1;
                            desc_out        <= desc_buf[0];
                            send_cnt        <= 6'd1;
                        end
                    end
                end
                // send_cnt wrapping back to zero marks the cycle after beat 63 was shown.
                SEND_DESC: begin
                    if (send_cnt == 6'd0) begin
                        state           <= LOAD_WIN;
                        desc_data_ready <= 1'b0;
                        desc_out        <= '0;
                        in_ready        <= 1'b1;
                        win_index       <= '0;
                    end else begin
                        desc_out <= desc_buf[send_cnt];
                        send_cnt <= send_cnt + 6'd1;
                    end
                end
                LOAD_WIN: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        win_out[32'(beat_cnt)*BEAT_W +: BEAT_W] <= beat_swz;
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == 6'd63) begin
                            state             <= FIRE_WIN;
                            in_ready          <= 1'b0;
                            window_data_ready <= 1'b1;
                        end
                    end
                end
                FIRE_WIN: begin
                    state <= WAIT_WIN;
                end
                WAIT_WIN: begin
                    if (done_with_window_data) begin
                        if (win_index == LAST_WIN) begin
                            state <= WAIT_DESC;
                        end else begin
                            win_index <= win_index + 9'd1;
                            state     <= LOAD_WIN;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                WAIT_DESC: begin
                    if (done_with_desc_data) begin
                        frame_done <= 1'b1;
                        win_index  <= '0;
                        state      <= LOAD_DESC;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD_DESC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ncc_data_feeder.sv
// Self-checking bench for ncc_data_feeder: reset vector table, directed frames and
// randomized frames checked against descriptor/window contents held in the bench.
module tb_ncc_data_feeder;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [35:0]   in_data;
    logic          in_ready;
    logic [35:0]   desc_out;
    logic          desc_data_ready;
    logic [2303:0] win_out;
    logic          window_data_ready;
    logic          done_with_window_data;
    logic          done_with_desc_data;
    logic [8:0]    win_index;
    logic          frame_done;

    ncc_data_feeder #(.NUM_WINDOWS(NW), .PIX_W(9)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_ready              (in_ready),
        .desc_out              (desc_out),
        .desc_data_ready       (desc_data_ready),
        .win_out               (win_out),
        .window_data_ready     (window_data_ready),
        .done_with_window_data (done_with_window_data),
        .done_with_desc_data   (done_with_desc_data),
        .win_index             (win_index),
        .frame_done            (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] desc_beats [64];
    logic [35:0] cur_beats  [64];
    logic [8:0]  win_pix    [256];

    // Expected field packs {in_ready, desc_data_ready, window_data_ready, frame_done, win_index}.
    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        dw;
        logic        dd;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [35:0] d,
                                 input logic w, input logic dsc);
        rst                   = r;
        in_valid              = v;
        in_data               = d;
        done_with_window_data = w;
        done_with_desc_data   = dsc;
    endtask

    task automatic fill_desc(input int mode);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) begin
            r = {$urandom, $urandom};
            case (mode)
                0:       desc_beats[k] = {9'd3, 9'd4, 9'd5, 9'd6};
                1:       desc_beats[k] = {9'(4*k), 9'(4*k+1), 9'(4*k+2), 9'(4*k+3)};
                default: desc_beats[k] = r[35:0];
            endcase
        end
    endtask

    task automatic fill_win(input int mode);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (mode)
                    0:       win_pix[r*16+c] = 9'd2;
                    1:       win_pix[r*16+c] = 9'(16*r + c);
                    default: win_pix[r*16+c] = 9'($urandom_range(0, 511));
                endcase
            end
        end
    endtask

    // Feeds n beats of cur_beats; mode 0 = back-to-back, 1 = valid every other cycle, 2 = random.
    task automatic send_beats(input int n, input int mode, input bit is_desc, output int cycles);
        int   k;
        logic v;
        logic acc;
        k = 0;
        cycles = 0;
        while (k < n && cycles < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            applyStimulus(1'b0, v, v ? cur_beats[k] : 36'($urandom), 1'b0, 1'b0);
            acc = v && in_ready;
            step();
            cycles++;
            if (acc) k++;
            if (is_desc && k < n) checkOutput("no_window_pulse_in_desc_load", window_data_ready, 1'b0);
        end
        in_valid = 1'b0;
        if (k < n) checkOutput("load_timeout_beats", k, n);
    endtask

    task automatic load_desc(input int mode, output int cycles);
        for (int k = 0; k < 64; k++) cur_beats[k] = desc_beats[k];
        send_beats(64, mode, 1'b1, cycles);
    endtask

    task automatic load_win(input int mode, output int cycles);
        for (int k = 0; k < 64; k++) begin
            cur_beats[k] = {win_pix[4*k], win_pix[4*k+1], win_pix[4*k+2], win_pix[4*k+3]};
        end
        send_beats(64, mode, 1'b0, cycles);
    endtask

    task automatic check_desc_burst();
        for (int k = 0; k < 64; k++) begin
            checkOutput($sformatf("desc_beat%0d", k), {desc_data_ready, in_ready, desc_out},
                        {1'b1, 1'b0, desc_beats[k]});
            applyStimulus(1'b0, 1'b1, 36'($urandom), 1'b0, 1'b0);
            step();
        end
        checkOutput("desc_burst_end", {desc_data_ready, in_ready, desc_out, win_index},
                    {1'b0, 1'b1, 36'd0, 9'd0});
        in_valid = 1'b0;
    endtask

    task automatic check_window(input string tag);
        int bad;
        int sel;
        bad = -1;
        for (int p = 0; p < 256; p++) begin
            if (win_out[p*9 +: 9] !== win_pix[p] && bad < 0) bad = p;
        end
        sel = (bad < 0) ? 0 : bad;
        checkOutput($sformatf("%s_px%0d", tag, sel), win_out[sel*9 +: 9], win_pix[sel]);
    endtask

    task automatic serve_window(input int idx, input bit last, input bit done_on_fire,
                                input bit early_dd, input bit both_last);
        int hold;
        checkOutput("fire_ctrl", {window_data_ready, in_ready, desc_data_ready}, 3'b100);
        checkOutput("fire_win_index", win_index, idx);
        check_window("fire_win");
        applyStimulus(1'b0, 1'b1, 36'($urandom), done_on_fire, 1'b0);
        step();
        checkOutput("after_fire_ctrl", {window_data_ready, in_ready, frame_done}, 3'b000);
        hold = done_on_fire ? $urandom_range(2, 5) : $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) begin
            applyStimulus(1'b0, 1'b1, 36'($urandom), 1'b0, early_dd && (h == 0));
            step();
            checkOutput("wait_win_ctrl", {window_data_ready, in_ready, frame_done}, 3'b000);
        end
        check_window("wait_win_stable");
        applyStimulus(1'b0, 1'b1, 36'($urandom), 1'b1, both_last && last);
        step();
        applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b0);
        if (!last) begin
            checkOutput("win_done_next", {in_ready, frame_done, win_index}, {1'b1, 1'b0, 9'(idx + 1)});
        end else begin
            checkOutput("win_done_last", {in_ready, frame_done, win_index}, {1'b0, 1'b0, 9'(idx)});
        end
    endtask

    task automatic finish_frame(input int idle);
        for (int i = 0; i < idle; i++) begin
            step();
            checkOutput("wait_desc_idle", {frame_done, in_ready, window_data_ready}, 3'b000);
        end
        applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b1);
        step();
        done_with_desc_data = 1'b0;
        checkOutput("frame_done_pulse", {frame_done, in_ready, win_index}, {1'b1, 1'b1, 9'd0});
        step();
        checkOutput("frame_done_clear", {frame_done, in_ready}, 2'b01);
    endtask

    task automatic run_random_frame();
        int cyc;
        fill_desc(2);
        load_desc($urandom_range(0, 2), cyc);
        check_desc_burst();
        for (int w = 0; w < NW; w++) begin
            fill_win(2);
            load_win($urandom_range(0, 2), cyc);
            serve_window(w, w == NW - 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        end
        finish_frame($urandom_range(0, 3));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;

        vecs[0] = '{rst: 1'b1, valid: 1'b0, dw: 1'b0, dd: 1'b0, exp: 13'h0000};
        vecs[1] = '{rst: 1'b1, valid: 1'b1, dw: 1'b1, dd: 1'b1, exp: 13'h0000};
        vecs[2] = '{rst: 1'b0, valid: 1'b0, dw: 1'b1, dd: 1'b1, exp: 13'h1000};
        vecs[3] = '{rst: 1'b0, valid: 1'b0, dw: 1'b1, dd: 1'b0, exp: 13'h1000};
        vecs[4] = '{rst: 1'b0, valid: 1'b0, dw: 1'b0, dd: 1'b1, exp: 13'h1000};

        applyStimulus(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, 36'($urandom), vecs[i].dw, vecs[i].dd);
            step();
            checkOutput($sformatf("reset_vec%0d", i),
                        {in_ready, desc_data_ready, window_data_ready, frame_done, win_index},
                        vecs[i].exp);
            if (i < 2) begin
                checkOutput($sformatf("reset_vec%0d_desc_out", i), desc_out, 36'd0);
                checkOutput($sformatf("reset_vec%0d_win_out", i), |win_out, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b0);

        $display("[TB] frame A: constant descriptor, directed windows");
        fill_desc(0);
        load_desc(0, cyc);
        check_desc_burst();
        fill_win(0);
        load_win(0, cyc);
        serve_window(0, 1'b0, 1'b0, 1'b0, 1'b0);
        fill_win(1);
        load_win(2, cyc);
        serve_window(1, 1'b0, 1'b1, 1'b1, 1'b0);
        fill_win(2);
        load_win(1, cyc);
        serve_window(2, 1'b0, 1'b0, 1'b1, 1'b0);
        fill_win(2);
        load_win(2, cyc);
        serve_window(3, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_frame(3);

        $display("[TB] frame B: stalled descriptor load, both dones on last window");
        fill_desc(1);
        load_desc(1, cyc);
        checkOutput("desc_toggle_load_cycles", cyc, 127);
        check_desc_burst();
        for (int w = 0; w < NW; w++) begin
            fill_win(2);
            load_win(2, cyc);
            serve_window(w, w == NW - 1, 1'b0, 1'b0, 1'b1);
        end
        finish_frame(2);

        $display("[TB] randomized frames");
        for (int f = 0; f < 3; f++) run_random_frame();

        $display("[TB] reset during window load");
        fill_desc(2);
        load_desc(0, cyc);
        check_desc_burst();
        fill_win(2);
        load_win(0, cyc);
        serve_window(0, 1'b0, 1'b0, 1'b0, 1'b0);
        fill_win(2);
        for (int k = 0; k < 64; k++) begin
            cur_beats[k] = {win_pix[4*k], win_pix[4*k+1], win_pix[4*k+2], win_pix[4*k+3]};
        end
        send_beats(30, 0, 1'b0, cyc);
        applyStimulus(1'b1, 1'b1, 36'($urandom), 1'b1, 1'b1);
        step();
        checkOutput("midrst_ctrl",
                    {in_ready, desc_data_ready, window_data_ready, frame_done, win_index}, 13'h0);
        checkOutput("midrst_desc_out", desc_out, 36'd0);
        checkOutput("midrst_win_out", |win_out, 1'b0);
        applyStimulus(1'b0, 1'b0, 36'd0, 1'b0, 1'b0);
        step();
        checkOutput("midrst_ready_back", in_ready, 1'b1);
        fill_desc(2);
        load_desc(2, cyc);
        check_desc_burst();
        for (int w = 0; w < NW; w++) begin
            fill_win(2);
            load_win(0, cyc);
            serve_window(w, w == NW - 1, 1'b0, 1'b0, 1'b0);
        end
        finish_frame(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
